stopwatch_sec_counter: RTL and testbench

- Upstream stage of the two-digit seconds display.
- Debounces two push-buttons and runs a start/stop/clear state machine.
- Divides the board clock down to a 1 Hz tick and keeps a 0..59 seconds count.
- The 6-bit `count` output feeds the tens/units 7-segment decoder directly.

---
 rtl/stopwatch_sec_counter.sv | 136 +++++++++++++
 tb/tb_stopwatch_sec_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sec_counter.sv
// Seconds counter for a two-digit stopwatch: debounced start/stop and clear buttons,
// an IDLE/RUN/PAUSE controller, a 1 Hz prescaler and a 0..MAX_VAL seconds count.
module stopwatch_sec_counter #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned MAX_VAL   = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [5:0] count,
    output logic       running,
    output logic       wrap
);

    localparam int unsigned DcW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam logic [DcW-1:0]  DcLast   = DcW'(DB_CYCLES - 1);
    localparam logic [PreW-1:0] PreLast  = PreW'(TICK_DIV - 1);
    localparam logic [5:0]      CountMax = 6'(MAX_VAL);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    // Bit 0 is start/stop, bit 1 is clear; both buttons share identical conditioning.
    logic [1:0]          btn_raw;
    logic [1:0]          s1_q, s2_q;
    logic [1:0]          db_q, db_d, db_prev_q;
    logic [1:0][DcW-1:0] dc_q, dc_d;
    logic [1:0]          press;
    logic                ss_press, clr_press;

    state_e          state_q, state_d;
    logic            running_q, running_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [5:0]      count_q, count_d;
    logic            wrap_q, wrap_d;
    logic            tick;

    assign btn_raw = {btn_clear, btn_start_stop};

    always_comb begin
        db_d = db_q;
        dc_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (dc_q[i] == DcLast) begin
                    db_d[i] = s2_q[i];
                end else begin
                    dc_d[i] = dc_q[i] + DcW'(1);
                end
            end
        end
        press = db_q & ~db_prev_q;
    end

    assign ss_press  = press[0];
    assign clr_press = press[1];

    // State register; reset is synchronous and wins over every other event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            dc_q      <= '0;
            state_q   <= StIdle;
            running_q <= 1'b0;
            pre_q     <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            dc_q      <= dc_d;
            state_q   <= state_d;
            running_q <= running_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
        end
    end

    // Clear outranks start/stop when both presses land in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = StIdle;
        end else if (ss_press) begin
            unique case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == StRun);
    end

    // Prescaler only advances in RUN, keeps its phase across PAUSE and is zero in IDLE.
    always_comb begin
        tick    = (state_q == StRun) && (pre_q == PreLast);
        pre_d   = pre_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr_press) begin
            pre_d   = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                StRun:   pre_d = tick ? '0 : pre_q + PreW'(1);
                StPause: pre_d = pre_q;
                default: pre_d = '0;
            endcase
            if (tick) begin
                if (count_q >= CountMax) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 6'd1;
                end
            end
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_sec_counter.sv
// Directed bench for stopwatch_sec_counter with TICK_DIV=4, DB_CYCLES=3, MAX_VAL=59.
module tb_stopwatch_sec_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start_stop;
    logic       btn_clear;
    logic [5:0] count;
    logic       running;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_sec_counter #(
        .TICK_DIV (4),
        .DB_CYCLES(3),
        .MAX_VAL  (59)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .count         (count),
        .running       (running),
        .wrap          (wrap)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the given buttons for 6 edges; the controller reacts on the 6th, then release.
    task automatic press(input logic ss, input logic clr);
        btn_start_stop = ss;
        btn_clear      = clr;
        repeat (6) step();
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            n_checks++;
            if ({count, running, wrap} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d count=%0d running=%b wrap=%b want 0/0/0",
                         i, count, running, wrap);
            end
        end
    endtask

    task automatic test_glitch();
        btn_start_stop = 1'b1;
        repeat (2) step();
        btn_start_stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (running !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_reject cyc=%0d running=%b want 0", i, running);
            end
        end
    endtask

    // Start latency, then first 8 cycles of counting; pause/resume continues from here.
    task automatic test_start_and_count();
        btn_start_stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (running !== 1'b0) begin
                n_fail++;
                $display("FAIL start_latency_early edge=%0d running=%b want 0", i, running);
            end
        end
        step();
        btn_start_stop = 1'b0;
        n_checks++;
        if (running !== 1'b1 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL start_latency edge=5 running=%b count=%0d want 1/0", running, count);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (count !== 6'(k / 4) || running !== 1'b1) begin
                n_fail++;
                $display("FAIL first_ticks k=%0d count=%0d running=%b want %0d/1",
                         k, count, running, k / 4);
            end
        end
    endtask

    task automatic test_pause_resume();
        press(1'b1, 1'b0);
        n_checks++;
        if (running !== 1'b0 || count !== 6'd3) begin
            n_fail++;
            $display("FAIL pause_enter running=%b count=%0d want 0/3", running, count);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (running !== 1'b0 || count !== 6'd3) begin
                n_fail++;
                $display("FAIL pause_hold cyc=%0d running=%b count=%0d want 0/3",
                         i, running, count);
            end
        end
        press(1'b1, 1'b0);
        n_checks++;
        if (running !== 1'b1 || count !== 6'd3) begin
            n_fail++;
            $display("FAIL resume_enter running=%b count=%0d want 1/3", running, count);
        end
        step();
        n_checks++;
        if (count !== 6'd3) begin
            n_fail++;
            $display("FAIL resume_phase_early count=%0d want 3", count);
        end
        step();
        n_checks++;
        if (count !== 6'd4) begin
            n_fail++;
            $display("FAIL resume_phase count=%0d want 4", count);
        end
    endtask

    // Clear, restart from 0 and run through 60 ticks plus one tick period.
    task automatic test_wrap();
        press(1'b0, 1'b1);
        n_checks++;
        if (running !== 1'b0 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL clear_from_run running=%b count=%0d want 0/0", running, count);
        end
        repeat (5) step();
        press(1'b1, 1'b0);
        for (int k = 1; k <= 244; k++) begin
            step();
            n_checks++;
            if (count !== 6'((k / 4) % 60) || wrap !== (k == 240) || running !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_seq k=%0d count=%0d wrap=%b running=%b want %0d/%b/1",
                         k, count, wrap, running, (k / 4) % 60, (k == 240));
            end
        end
    endtask

    task automatic test_clear_priority();
        repeat (59) step();
        n_checks++;
        if (count !== 6'd15) begin
            n_fail++;
            $display("FAIL pre_clear_count count=%0d want 15", count);
        end
        press(1'b1, 1'b1);
        n_checks++;
        if (running !== 1'b0 || count !== 6'd0) begin
            n_fail++;
            $display("FAIL clear_and_ss running=%b count=%0d want 0/0", running, count);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (running !== 1'b0 || count !== 6'd0) begin
                n_fail++;
                $display("FAIL clear_and_ss_hold cyc=%0d running=%b count=%0d want 0/0",
                         i, running, count);
            end
        end
        press(1'b1, 1'b0);
        repeat (234) step();
        n_checks++;
        if (count !== 6'd58 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_tick_clear count=%0d running=%b want 58/1", count, running);
        end
        press(1'b0, 1'b1);
        n_checks++;
        if (count !== 6'd0 || wrap !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_on_tick count=%0d wrap=%b running=%b want 0/0/0",
                     count, wrap, running);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (count !== 6'd0 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_on_tick_hold cyc=%0d count=%0d wrap=%b want 0/0",
                         i, count, wrap);
            end
        end
    endtask

    task automatic test_reset_mid();
        press(1'b1, 1'b0);
        repeat (168) step();
        n_checks++;
        if (count !== 6'd42 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset count=%0d running=%b want 42/1", count, running);
        end
        btn_start_stop = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        btn_start_stop = 1'b0;
        step();
        n_checks++;
        if (count !== 6'd0 || running !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid count=%0d running=%b wrap=%b want 0/0/0",
                     count, running, wrap);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (count !== 6'd0 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_hold cyc=%0d count=%0d running=%b want 0/0",
                         i, count, running);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start_and_count();
        test_pause_resume();
        test_wrap();
        test_clear_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
